// File: rtl/scan_display.sv
// scan_display: multiplexed seven-segment scan driver.
// Scans DIGITS common-anode digits, one per clock, from one of MODES nibble banks.
// The bank is switched only at frame start so a frame never mixes banks.
// Also provides per-digit blink, a per-digit decimal point and leading-zero blanking.
// All outputs are registered and always describe the same digit in the same cycle.
module scan_display #(
  parameter int DIGITS     = 8,
  parameter int MODES      = 4,
  parameter int BLINK_HALF = 250
) (
  input  logic                        clk_1khz,
  input  logic                        rst,
  input  logic [$clog2(MODES)-1:0]    mode,
  input  logic [MODES*DIGITS*4-1:0]   in,
  input  logic [DIGITS-1:0]           blink_mask,
  input  logic [DIGITS-1:0]           dot_mask,
  input  logic                        blank_lz,
  output logic [7:0]                  decodeout,
  output logic [DIGITS-1:0]           ds
);
  localparam int PW = $clog2(DIGITS);
  localparam int MW = $clog2(MODES);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PW-1:0] LAST  = PW'(DIGITS - 1);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_HALF - 1);

  // Hex nibble to {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic [MODES-1:0][DIGITS-1:0][3:0] bank;
  logic [DIGITS-1:0][3:0]            cur;
  logic [DIGITS-1:0]                 nz, lz;

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [MW-1:0]     mode_q, mode_d, mode_eff;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              bphase_q, bphase_d;
  logic [DIGITS-1:0] ds_q, ds_d;
  logic [7:0]        seg_q, seg_d;
  logic              bank_ok, lz_blank;

  // Packed view of the input bus: bank[m][i] is digit i of bank m.
  assign bank = in;

  // Per digit: nonzero flag, and "this digit and everything above it is zero".
  for (genvar i = 0; i < DIGITS; i++) begin : g_lz
    assign nz[i] = |cur[i];
    assign lz[i] = ~|nz[DIGITS-1:i];
  end

  // Scan pointer, frame-latched bank, blink timer and next output word.
  always_comb begin
    ptr_d    = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
    mode_eff = (ptr_d == '0) ? mode : mode_q;
    mode_d   = mode_eff;
    bank_ok  = int'(mode_eff) < MODES;
    cur      = bank_ok ? bank[mode_eff] : '0;
    bcnt_d   = (bcnt_q == BLAST) ? '0 : bcnt_q + BW'(1);
    bphase_d = (bcnt_q == BLAST) ? ~bphase_q : bphase_q;
    lz_blank = blank_lz && (ptr_d != '0) && lz[ptr_d];
    seg_d    = {dot_mask[ptr_d], lz_blank ? 7'h00 : hex7(cur[ptr_d])};
    // Blink and an out-of-range bank both darken the whole digit, dp included.
    if (!bank_ok || (bphase_q && blink_mask[ptr_d])) seg_d = '0;
    ds_d     = ~(DIGITS'(1) << ptr_d);
  end

  // State and output registers; reset parks the pointer so the first edge shows digit 0.
  always_ff @(posedge clk_1khz or negedge rst) begin
    if (!rst) begin
      ptr_q    <= LAST;
      mode_q   <= '0;
      bcnt_q   <= '0;
      bphase_q <= 1'b0;
      ds_q     <= '1;
      seg_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      mode_q   <= mode_d;
      bcnt_q   <= bcnt_d;
      bphase_q <= bphase_d;
      ds_q     <= ds_d;
      seg_q    <= seg_d;
    end
  end

  assign ds        = ds_q;
  assign decodeout = seg_q;
endmodule

// File: tb/tb_scan_display.sv
// Bench for scan_display: frame-level reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_scan_display;
  localparam int D  = 8;
  localparam int M  = 3;   // not a power of two, so bank 3 is out of range
  localparam int BH = 3;

  logic         clk, rst, blank_lz;
  logic [1:0]   mode;
  logic [M*D*4-1:0] in_v;
  logic [D-1:0] blink_mask, dot_mask;
  logic [7:0]   decodeout;
  logic [D-1:0] ds;

  int pass_cnt = 0;
  int total    = 0;

  scan_display #(.DIGITS(D), .MODES(M), .BLINK_HALF(BH)) dut (
    .clk_1khz(clk), .rst(rst), .mode(mode), .in(in_v),
    .blink_mask(blink_mask), .dot_mask(dot_mask), .blank_lz(blank_lz),
    .decodeout(decodeout), .ds(ds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Reference model: edge n after reset shows digit n mod D; bank chosen at digit 0;
  // blink phase is (edges before this one / BH) mod 2; leading zeros from the bank value.
  logic [7:0] seg_tbl [16];
  initial seg_tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  int n, md, mph, fbank;
  logic [31:0] bv;
  logic [7:0]  exp_ds, exp_dec;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n = 0; fbank = 0; exp_ds = 8'hFF; exp_dec = 8'h00;
    end else begin
      md  = n % D;
      mph = (n / BH) % 2;
      n++;
      if (md == 0) fbank = int'(mode);
      exp_ds = ~(8'd1 << md);
      if (fbank >= M || (mph == 1 && blink_mask[md])) exp_dec = 8'h00;
      else begin
        bv = in_v[fbank*32 +: 32];
        if (blank_lz && md > 0 && (bv >> (4*md)) == 0) exp_dec = 8'h00;
        else exp_dec = seg_tbl[(bv >> (4*md)) & 32'hF];
        if (dot_mask[md]) exp_dec = exp_dec | 8'h80;
      end
    end
  end

  // Every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("model_ds", ds, exp_ds);
    chk("model_dec", decodeout, exp_dec);
  end

  // Advance at least one cycle, then until digit d is enabled (bounded).
  task automatic goto_digit(input int d);
    int k = 0;
    do begin
      @(negedge clk); k++;
    end while (ds !== ~(8'd1 << d) && k < 3*D);
    if (ds !== ~(8'd1 << d)) chk("goto_timeout", ds, ~(8'd1 << d));
  endtask

  initial begin
    logic [7:0] lit [8];
    int lit_n, dark_n;
    lit = '{8'hBF, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
    rst = 1'b0; mode = 2'd0; in_v = '0; blink_mask = '0; dot_mask = 8'h01; blank_lz = 1'b0;
    in_v[31:0] = 32'h76543210;
    repeat (3) @(negedge clk);
    chk("reset_ds", ds, 8'hFF);
    chk("reset_dec", decodeout, 8'h00);
    rst = 1'b1;
    // Decode over the first frame; first enabled digit is 0.
    for (int d = 0; d < D; d++) begin
      @(negedge clk);
      chk("scan_ds", ds, ~(8'd1 << d));
      chk("decode", decodeout, lit[d]);
    end
    @(negedge clk);
    chk("wrap_ds", ds, 8'hFE);

    // Tear-free switch requested while digit 3 is shown.
    in_v[31:0] = 32'h11111111; in_v[63:32] = 32'h22222222; dot_mask = '0;
    goto_digit(3);
    mode = 2'd1;
    for (int d = 4; d < D; d++) begin
      @(negedge clk);
      chk("tearfree_old", decodeout, 8'h06);
    end
    @(negedge clk);
    chk("tearfree_ds", ds, 8'hFE);
    chk("tearfree_new", decodeout, 8'h5B);

    // Leading-zero blanking.
    mode = 2'd0; in_v[31:0] = 32'h00000305; blank_lz = 1'b1;
    goto_digit(0);
    chk("lz_d0", decodeout, 8'h6D);
    @(negedge clk); chk("lz_d1", decodeout, 8'h3F);
    @(negedge clk); chk("lz_d2", decodeout, 8'h4F);
    for (int d = 3; d < D; d++) begin
      @(negedge clk); chk("lz_hi", decodeout, 8'h00);
    end
    in_v[31:0] = 32'h0;
    @(negedge clk); chk("lz_zero_d0", decodeout, 8'h3F);
    @(negedge clk); chk("lz_zero_d1", decodeout, 8'h00);

    // Out-of-range bank blanks everything, dp included.
    mode = 2'd3; dot_mask = 8'hFF;
    goto_digit(0);
    chk("badbank_d0", decodeout, 8'h00);
    @(negedge clk); chk("badbank_d1", decodeout, 8'h00);
    mode = 2'd0; dot_mask = '0; blank_lz = 1'b0;

    // Blink digit 1 (value 8). Over 3 frames digit 1 lands on phases 0,1,1.
    in_v[31:0] = 32'h00000080; blink_mask = 8'h02;
    goto_digit(0);
    lit_n = 0; dark_n = 0;
    for (int k = 0; k < 3*D; k++) begin
      @(negedge clk);
      if (ds === 8'hFD) begin
        if (decodeout === 8'h7F) lit_n++;
        else if (decodeout === 8'h00) dark_n++;
      end
      if (ds === 8'hFB) chk("blink_other", decodeout, 8'h3F);
    end
    chk("blink_lit", 8'(lit_n), 8'd1);
    chk("blink_dark", 8'(dark_n), 8'd2);
    blink_mask = '0;

    // Async reset between edges while digit 5 is enabled.
    goto_digit(5);
    #2 rst = 1'b0;
    #1;
    chk("async_ds", ds, 8'hFF);
    chk("async_dec", decodeout, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("restart_ds", ds, 8'hFE);
    chk("restart_dec", decodeout, 8'h3F);
    repeat (D) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
